// File: rtl/vram_pkg.sv
// Shared types and default widths for the video RAM arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vram_pkg;

  // Default geometry of the 2 KiB video RAM and the timing limits.
  localparam int ADDR_WIDTH_DEF   = 11;
  localparam int DATA_WIDTH_DEF   = 8;
  localparam int CPU_MAX_WAIT_DEF = 6;
  localparam int VID_DEADLINE_DEF = 7;

  // Arbiter FSM: grant cycle (IDLE), RAM cycle (ACC), completion (DONE).
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Which requester owns the transaction in flight.
  typedef enum logic {
    VID = 1'b0,
    CPU = 1'b1
  } owner_t;

  // Counter width able to hold 0..limit inclusive.
  function automatic int age_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// Bundle of the video fetch, CPU strobe and RAM macro signals.
// Latency: n/a (wiring only).
// Backpressure: requests are levels held until their one-cycle ack/ready pulse.
interface vram_arbiter_if
  import vram_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

  // Video scan-out fetch port
  logic                  vid_req;
  logic [ADDR_WIDTH-1:0] vid_addr;
  logic                  vid_ack;
  logic [DATA_WIDTH-1:0] vid_data;

  // CPU strobe port
  logic                  cpu_strobe;
  logic                  cpu_write;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic                  cpu_ready;
  logic [DATA_WIDTH-1:0] cpu_rdata;

  // RAM macro port
  logic                  ram_en;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Status
  logic                  vid_overrun;

  // Arbiter side
  modport slave (
    input  vid_req, vid_addr,
    input  cpu_strobe, cpu_write, cpu_addr, cpu_wdata,
    input  ram_rdata,
    output vid_ack, vid_data,
    output cpu_ready, cpu_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata,
    output vid_overrun
  );

  // Requester / RAM side
  modport master (
    output vid_req, vid_addr,
    output cpu_strobe, cpu_write, cpu_addr, cpu_wdata,
    output ram_rdata,
    input  vid_ack, vid_data,
    input  cpu_ready, cpu_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    input  vid_overrun
  );

endinterface

// File: rtl/vram_age_counter.sv
// Saturating wait-cycle counter with a "limit reached" compare output.
// Latency: count updates one cycle after en/clr; reached is combinational on count.
// Backpressure: none; clr has priority over en, counting stops at LIMIT.
module vram_age_counter
  import vram_pkg::*;
#(
  parameter int LIMIT = CPU_MAX_WAIT_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic reached
);

  localparam int            W   = age_width(LIMIT);
  localparam logic [W-1:0]  LIM = W'(LIMIT);

  logic [W-1:0] count;

  // Count enabled cycles, clear on request, hold once the limit is hit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count < LIM)) begin
      count <= count + 1'b1;
    end
  end

  assign reached = (count >= LIM);

endmodule

// File: rtl/vram_arbiter.sv
// Arbitrates a single-port sync-read video RAM between scan-out fetch and CPU strobes.
// Latency: fixed 3-cycle transaction; ack/ready pulses 2 cycles after the granting edge.
// Backpressure: requests wait in place (level held); video first unless CPU age expired.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int CPU_MAX_WAIT = CPU_MAX_WAIT_DEF,
  parameter int VID_DEADLINE = VID_DEADLINE_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  vram_arbiter_if.slave bus
);

  state_t                state;
  owner_t                owner;

  logic                  ram_en_q;
  logic                  ram_we_q;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [DATA_WIDTH-1:0] ram_wdata_q;
  logic                  vid_overrun_q;

  logic                  cpu_expired;
  logic                  vid_late;
  logic                  cpu_busy;
  logic                  cpu_grant;
  logic                  vid_grant;
  logic                  vid_ack_int;
  logic                  cpu_ready_int;

  // Completion pulses come only from registered state/owner, never from inputs.
  assign vid_ack_int   = (state == DONE) && (owner == VID);
  assign cpu_ready_int = (state == DONE) && (owner == CPU);
  assign cpu_busy      = (state != IDLE) && (owner == CPU);

  // IDLE arbitration: an aged CPU beats video, otherwise video beats CPU.
  assign cpu_grant = (state == IDLE) && bus.cpu_strobe && (cpu_expired || !bus.vid_req);
  assign vid_grant = (state == IDLE) && bus.vid_req && !cpu_grant;

  // CPU age: counts while the CPU waits, zero when idle or just granted.
  vram_age_counter #(
    .LIMIT (CPU_MAX_WAIT)
  ) u_cpu_age (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (!bus.cpu_strobe || cpu_grant),
    .en      (bus.cpu_strobe && !cpu_busy),
    .reached (cpu_expired)
  );

  // Video age: cycles from request rise until its ack.
  vram_age_counter #(
    .LIMIT (VID_DEADLINE)
  ) u_vid_age (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (!bus.vid_req || vid_ack_int),
    .en      (bus.vid_req && !vid_ack_int),
    .reached (vid_late)
  );

  // Transaction FSM with registered RAM controls; requests sampled only at grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      owner       <= VID;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cpu_grant) begin
            state       <= ACC;
            owner       <= CPU;
            ram_en_q    <= 1'b1;
            ram_we_q    <= bus.cpu_write;
            ram_addr_q  <= bus.cpu_addr;
            ram_wdata_q <= bus.cpu_wdata;
          end else if (vid_grant) begin
            state      <= ACC;
            owner      <= VID;
            ram_en_q   <= 1'b1;
            ram_we_q   <= 1'b0;
            ram_addr_q <= bus.vid_addr;
          end
        end
        ACC: begin
          // The single RAM cycle ends here; read data lands during DONE.
          state    <= DONE;
          ram_en_q <= 1'b0;
          ram_we_q <= 1'b0;
        end
        DONE: begin
          // No arbitration here, so a still-high request waits for IDLE.
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          ram_en_q <= 1'b0;
          ram_we_q <= 1'b0;
        end
      endcase
    end
  end

  // Sticky deadline-miss flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vid_overrun_q <= 1'b0;
    end else if (vid_late) begin
      vid_overrun_q <= 1'b1;
    end
  end

  assign bus.vid_ack     = vid_ack_int;
  assign bus.cpu_ready   = cpu_ready_int;
  assign bus.vid_data    = bus.ram_rdata;
  assign bus.cpu_rdata   = bus.ram_rdata;
  assign bus.ram_en      = ram_en_q;
  assign bus.ram_we      = ram_we_q;
  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_wdata   = ram_wdata_q;
  assign bus.vid_overrun = vid_overrun_q;

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Arbitrates a single-port, synchronous-read 2 KiB video RAM between the display scan-out fetch (one byte per 8 pixel clocks) and Z8 CPU strobe accesses. Every access is a fixed 3-cycle transaction: grant, RAM cycle, completion. Video has default priority. An age counter guarantees CPU progress, and a sticky flag reports any video fetch that misses its deadline. The block sits between the video generator, the CPU bus glue and the RAM macro.

## Interface
- ADDR_WIDTH, 11, RAM address width
- DATA_WIDTH, 8, RAM data width
- CPU_MAX_WAIT, 6, CPU wait cycles after which the CPU outranks video
- VID_DEADLINE, 7, cycles from `vid_req` rise to `vid_ack` before an overrun is flagged

Ports:
- clk  in  1  system clock, 4 MHz
- reset_n  in  1  reset, asynchronous, active-low
- vid_req  in  1  video fetch request, level, held until `vid_ack`
- vid_addr  in  ADDR_WIDTH  video fetch address
- vid_ack  out  1  one-cycle completion pulse; `vid_data` valid in this cycle
- vid_data  out  DATA_WIDTH  fetched byte (`ram_rdata` passthrough)
- cpu_strobe  in  1  CPU request, level, held until `cpu_ready`
- cpu_write  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_WIDTH  CPU address
- cpu_wdata  in  DATA_WIDTH  CPU write data
- cpu_ready  out  1  one-cycle completion pulse; `cpu_rdata` valid in this cycle for reads
- cpu_rdata  out  DATA_WIDTH  read byte (`ram_rdata` passthrough)
- ram_en, ram_we  out  1  RAM enable and write enable, registered
- ram_addr  out  ADDR_WIDTH  registered RAM address
- ram_wdata  out  DATA_WIDTH  registered RAM write data
- ram_rdata  in  DATA_WIDTH  RAM read data, valid one cycle after an `ram_en` cycle
- vid_overrun  out  1  sticky deadline-miss flag

## Operation
- FSM states:
  - IDLE: arbitrates. Winner moves to ACC, latches owner, and registers `ram_addr`, `ram_wdata` and `ram_we`; `ram_en` = 1 during ACC.
  - ACC: always moves to DONE.
  - DONE: pulses the owner's ack/ready, then always moves to IDLE. DONE never arbitrates, so a request still high in DONE is not re-granted.
- Arbitration in IDLE:
  - `cpu_age >= CPU_MAX_WAIT` and `cpu_strobe` → CPU wins.
  - Otherwise `vid_req` → video wins.
  - Otherwise `cpu_strobe` → CPU wins.
  - Otherwise stay in IDLE.
- `cpu_age`:
  - Width is ceil(log2(CPU_MAX_WAIT+1)) bits.
  - Increments while `cpu_strobe` is high and the CPU is not owner; saturates.
  - Cleared on a CPU grant or when `cpu_strobe` is low.
- Request inputs are sampled only at grant. Changes after grant do not affect the transaction in progress. A request dropped mid-transaction is still completed, and its ack is still pulsed.
- `vid_ack` and `cpu_ready` are decoded from the state and owner registers only; there is no input-to-output combinational path.
- `vid_overrun`:
  - `vid_age` counts cycles with `vid_req` high and `vid_ack` low.
  - Flag is set when `vid_age` reaches VID_DEADLINE.
  - Cleared only by reset.
- Reset mid-transaction: the access is abandoned, `ram_we` drops immediately, and no ack is issued afterwards.

## Timing
- Reset values:
  - state = IDLE
  - `ram_en`, `ram_we`, `ram_addr`, `ram_wdata` = 0
  - `vid_ack`, `cpu_ready`, `vid_overrun` = 0
  - `cpu_age`, `vid_age` = 0
- Latency: request seen in IDLE at edge E0 → ACC after E0 → DONE after E1 → ack high in the cycle after E1. Minimum is 2 cycles after the sampling edge.
- Issue rate: one transaction per 3 cycles.
- Worst-case video latency, CPU in flight and age not expired: 5 cycles. This fits the 8-cycle byte budget.
- Simultaneous requests in IDLE: video wins unless the CPU age has expired.
- Back-to-back CPU accesses cannot starve video: after a CPU transaction, IDLE re-arbitrates with `cpu_age` = 0.

## Structure
- `vram_pkg` holds:
  - the state enum (IDLE, ACC, DONE)
  - the owner enum (VID, CPU)
  - default widths
- Sub-module `vram_age_counter` (saturating, clear and enable inputs, compare output) is instantiated twice, for `cpu_age` and `vid_age`.

## Test plan
- Video read alone, `vid_addr`=0x123 with RAM holding 0xA5 → `ram_en` at 0x123 for 1 cycle; `vid_ack` with `vid_data`=0xA5 two cycles after the sampling edge.
- CPU write 0x3C to 0x7FF, then CPU read of 0x7FF → `ram_we` for exactly 1 cycle; read returns 0x3C with `cpu_ready`; transactions are 3 cycles apart.
- `vid_req` and `cpu_strobe` rise in the same cycle → video served first, then CPU; `cpu_age` = 3 at CPU grant.
- `vid_req` held continuously with CPU_MAX_WAIT=2 → CPU granted at the first IDLE after age reaches 2; `vid_overrun` stays 0.
- Test-only stretch with VID_DEADLINE=3: video blocked behind a CPU access → `vid_overrun` set and held until `reset_n` low.
- Assert `reset_n` during ACC of a CPU write → `ram_we` and `ram_en` drop asynchronously; no `cpu_ready`; state returns to IDLE.
